// File: rtl/rf_seq_pkg.sv
// rtl/rf_seq_pkg.sv - opcodes, FSM encoding and helpers shared by the register-file sequencer
package rf_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // LDI and NOP never touch the read ports, so they skip READ/EXEC
    function automatic logic needs_read(input logic [2:0] op);
        return !((op == OP_LDI) || (op == OP_NOP));
    endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// rtl/rf_op_sequencer_if.sv - command handshake and completion bundle of the register-file sequencer
interface rf_op_sequencer_if #(
    parameter int W = 8
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [3:0]   cmd_dst;
    logic [3:0]   cmd_src1;
    logic [3:0]   cmd_src2;
    logic [W-1:0] cmd_imm;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        input  cmd_ready, busy, done, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        output cmd_ready, busy, done, result
    );
endinterface

// File: rtl/rf_seq_alu.sv
// rtl/rf_seq_alu.sv - combinational ALU; carry is the add carry-out or the subtract borrow
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] imm,
    output logic [W-1:0] y,
    output logic         carry
);
    logic [W:0] wide;

    always_comb begin
        wide  = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                y     = wide[W-1:0];
                carry = wide[W];
            end
            OP_SUB: begin
                // the extra top bit wraps to 1 exactly when a < b unsigned
                wide  = {1'b0, a} - {1'b0, b};
                y     = wide[W-1:0];
                carry = wide[W];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            OP_LDI:  y = imm;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/rf_op_sequencer.sv
// rtl/rf_op_sequencer.sv - read/exec/writeback sequencer for the 16-entry register file; optional flags under RF_SEQ_FLAGS_EN
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                reset,
    rf_op_sequencer_if.slave    cmd,
    output logic [3:0]          rf_src_sel1,
    output logic [3:0]          rf_src_sel2,
    output logic [3:0]          rf_dest_sel,
    output logic                rf_wrt_enable,
    output logic [W-1:0]        rf_wrt_data,
    input  logic [W-1:0]        rf_read_data1,
    input  logic [W-1:0]        rf_read_data2
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic                flag_zero,
    output logic                flag_carry
`endif
);
    state_t       state;
    state_t       state_nx;
    logic         accept;

    logic [2:0]   op_q;
    logic [3:0]   dst_q;
    logic [3:0]   src1_q;
    logic [3:0]   src2_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] opa_q;
    logic [W-1:0] opb_q;
    logic [W-1:0] res_q;
    logic         carry_q;

    logic [W-1:0] alu_y;
    logic         alu_carry;

    assign accept = (state == ST_IDLE) && cmd.cmd_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Register-file outputs decode straight from state, so an asynchronous
    // reset drops the write enable without waiting for a clock edge.
    always_comb begin
        state_nx      = state;
        cmd.cmd_ready = 1'b0;
        cmd.done      = 1'b0;
        rf_src_sel1   = '0;
        rf_src_sel2   = '0;
        rf_dest_sel   = '0;
        rf_wrt_enable = 1'b0;
        rf_wrt_data   = '0;
        case (state)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    state_nx = needs_read(cmd.cmd_op) ? ST_READ : ST_WB;
                end
            end
            ST_READ: begin
                rf_src_sel1 = src1_q;
                rf_src_sel2 = src2_q;
                state_nx    = ST_EXEC;
            end
            ST_EXEC: begin
                state_nx = ST_WB;
            end
            ST_WB: begin
                rf_dest_sel   = dst_q;
                rf_wrt_data   = res_q;
                rf_wrt_enable = (op_q != OP_NOP);
                cmd.done      = 1'b1;
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        cmd.busy = !cmd.cmd_ready;
    end

    rf_seq_alu #(.W(W)) u_alu (
        .op    (op_q),
        .a     (opa_q),
        .b     (opb_q),
        .imm   (imm_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= cmd.cmd_op;
                dst_q  <= cmd.cmd_dst;
                src1_q <= cmd.cmd_src1;
                src2_q <= cmd.cmd_src2;
                imm_q  <= cmd.cmd_imm;
                // LDI/NOP go straight to WB, so their result is staged here
                if (cmd.cmd_op == OP_LDI) begin
                    res_q   <= cmd.cmd_imm;
                    carry_q <= 1'b0;
                end else if (cmd.cmd_op == OP_NOP) begin
                    res_q   <= '0;
                    carry_q <= 1'b0;
                end
            end
            if (state == ST_READ) begin
                opa_q <= rf_read_data1;
                opb_q <= rf_read_data2;
            end
            if (state == ST_EXEC) begin
                res_q   <= alu_y;
                carry_q <= alu_carry;
            end
        end
    end

    assign cmd.result = res_q;

`ifdef RF_SEQ_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else if (state == ST_WB) begin
            case (op_q)
                OP_NOP: ;
                OP_MOV, OP_LDI: begin
                    flag_zero  <= (res_q == '0);
                    flag_carry <= 1'b0;
                end
                default: begin
                    flag_zero  <= (res_q == '0);
                    flag_carry <= carry_q;
                end
            endcase
        end
    end
`else
    logic unused_carry;
    assign unused_carry = carry_q;
`endif

endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb/tb_rf_op_sequencer.sv - directed scoreboard bench for rf_op_sequencer (flag checks under RF_SEQ_FLAGS_EN)
module tb_rf_op_sequencer;
    import rf_seq_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rf_op_sequencer_if #(.W(W)) bus ();

    logic [3:0]   rf_src_sel1, rf_src_sel2, rf_dest_sel;
    logic         rf_wrt_enable;
    logic [W-1:0] rf_wrt_data;
    logic [W-1:0] rf_read_data1, rf_read_data2;
`ifdef RF_SEQ_FLAGS_EN
    logic         flag_zero, flag_carry;
`endif

    logic [W-1:0] rf_mem [16];
    assign rf_read_data1 = rf_mem[rf_src_sel1];
    assign rf_read_data2 = rf_mem[rf_src_sel2];
    always @(posedge clk) if (rf_wrt_enable) rf_mem[rf_dest_sel] <= rf_wrt_data;

    rf_op_sequencer #(.W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (bus.slave),
        .rf_src_sel1   (rf_src_sel1),
        .rf_src_sel2   (rf_src_sel2),
        .rf_dest_sel   (rf_dest_sel),
        .rf_wrt_enable (rf_wrt_enable),
        .rf_wrt_data   (rf_wrt_data),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
`ifdef RF_SEQ_FLAGS_EN
        ,
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry)
`endif
    );

    typedef struct {
        logic [2:0]   op;
        logic [3:0]   dst;
        logic [W-1:0] data;
        logic         we;
        logic         carry;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] mdl [16];
    logic         exp_z = 1'b0;
    logic         exp_c = 1'b0;
    bit           watch = 1'b0;
    int           wr_seen = 0;

    always @(posedge clk) if (watch && (rf_wrt_enable || bus.done)) wr_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] imm);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_MOV:  return {1'b0, a};
            OP_LDI:  return {1'b0, imm};
            default: return '0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [W-1:0] imm);
        bus.cmd_op   = op;
        bus.cmd_dst  = dst;
        bus.cmd_src1 = s1;
        bus.cmd_src2 = s2;
        bus.cmd_imm  = imm;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [W-1:0] imm);
        exp_t       e;
        logic [W:0] r;
        r       = ref_alu(op, mdl[s1], mdl[s2], imm);
        e.op    = op;
        e.dst   = dst;
        e.data  = r[W-1:0];
        e.we    = (op != OP_NOP);
        e.carry = r[W];
        if (e.we) mdl[dst] = e.data;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, ":sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ":wrt_enable"}, 32'(rf_wrt_enable), 32'(e.we));
            check({tag, ":dest_sel"}, 32'(rf_dest_sel), 32'(e.dst));
            if (e.we) begin
                check({tag, ":wrt_data"}, 32'(rf_wrt_data), 32'(e.data));
                check({tag, ":result"}, 32'(bus.result), 32'(e.data));
            end
            if (e.op == OP_MOV || e.op == OP_LDI) begin
                exp_z = (e.data == '0);
                exp_c = 1'b0;
            end else if (e.op != OP_NOP) begin
                exp_z = (e.data == '0);
                exp_c = e.carry;
            end
        end
    endtask

    task automatic check_flags(input string tag);
`ifdef RF_SEQ_FLAGS_EN
        check({tag, ":flag_zero"}, 32'(flag_zero), 32'(exp_z));
        check({tag, ":flag_carry"}, 32'(flag_carry), 32'(exp_c));
`else
        check({tag, ":idle_ready"}, 32'(bus.cmd_ready), 32'd1);
`endif
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] dst,
                           input logic [3:0] s1, input logic [3:0] s2, input logic [W-1:0] imm);
        int lat;
        bit seen;
        lat = (op == OP_LDI || op == OP_NOP) ? 1 : 3;
        @(negedge clk);
        check({tag, ":ready"}, 32'(bus.cmd_ready), 32'd1);
        drive(op, dst, s1, s2, imm);
        bus.cmd_valid = 1'b1;
        push_exp(op, dst, s1, s2, imm);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 6 && !seen; c++) begin
            @(negedge clk);
            check({tag, ":busy"}, 32'(bus.busy), 32'd1);
            if (c == 1 && lat == 3) begin
                check({tag, ":src_sel1"}, 32'(rf_src_sel1), 32'(s1));
                check({tag, ":src_sel2"}, 32'(rf_src_sel2), 32'(s2));
            end
            if (bus.done) begin
                seen = 1'b1;
                check({tag, ":latency"}, 32'(c), 32'(lat));
                pop_check(tag);
            end else begin
                check({tag, ":no_write_early"}, 32'(rf_wrt_enable), 32'd0);
            end
        end
        if (!seen) check({tag, ":done_timeout"}, 32'(bus.done), 32'd1);
        @(negedge clk);
        check({tag, ":ready_after"}, 32'(bus.cmd_ready), 32'd1);
        check_flags(tag);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = '0;
            mdl[i]    = '0;
        end
        bus.cmd_valid = 1'b0;
        drive(OP_NOP, 4'd0, 4'd0, 4'd0, '0);

        #2;
        check("rst:cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:wrt_enable", 32'(rf_wrt_enable), 32'd0);
        check("rst:result", 32'(bus.result), 32'd0);
        check("rst:rf_sels", 32'({rf_src_sel1, rf_src_sel2, rf_dest_sel}), 32'd0);
        check("rst:wrt_data", 32'(rf_wrt_data), 32'd0);
        check_flags("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_cmd("ldi_r3", OP_LDI, 4'd3, 4'd0, 4'd0, 8'h12);
        run_cmd("ldi_r4", OP_LDI, 4'd4, 4'd0, 4'd0, 8'h34);
        run_cmd("add_r5", OP_ADD, 4'd5, 4'd3, 4'd4, 8'h00);
        run_cmd("sub_r6", OP_SUB, 4'd6, 4'd3, 4'd4, 8'h00);
        run_cmd("ldi_r7", OP_LDI, 4'd7, 4'd0, 4'd0, 8'hFF);
        run_cmd("ldi_r8", OP_LDI, 4'd8, 4'd0, 4'd0, 8'h01);
        run_cmd("add_wrap", OP_ADD, 4'd9, 4'd7, 4'd8, 8'h00);
        run_cmd("xor_r12", OP_XOR, 4'd12, 4'd6, 4'd7, 8'h00);
        run_cmd("and_r13", OP_AND, 4'd13, 4'd3, 4'd6, 8'h00);
        run_cmd("or_r14", OP_OR, 4'd14, 4'd3, 4'd4, 8'h00);

        // ADD r3=r3+r3 then NOP with cmd_valid held high throughout
        @(negedge clk);
        drive(OP_ADD, 4'd3, 4'd3, 4'd3, '0);
        bus.cmd_valid = 1'b1;
        push_exp(OP_ADD, 4'd3, 4'd3, 4'd3, '0);
        @(posedge clk);
        #1 drive(OP_NOP, 4'd0, 4'd0, 4'd0, 8'hAA);
        push_exp(OP_NOP, 4'd0, 4'd0, 4'd0, 8'hAA);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("held:ready_low", 32'(bus.cmd_ready), 32'd0);
            if (c == 3) begin
                check("held:add_done", 32'(bus.done), 32'd1);
                pop_check("held_add");
            end
        end
        @(negedge clk);
        check("held:ready_c4", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("held:nop_done", 32'(bus.done), 32'd1);
        pop_check("held_nop");
        @(negedge clk);
        check_flags("held_nop");

        run_cmd("ldi_r10", OP_LDI, 4'd10, 4'd0, 4'd0, 8'h5A);

        // reset during EXEC of ADD r10=r3+r4 must discard it
        @(negedge clk);
        drive(OP_ADD, 4'd10, 4'd3, 4'd4, '0);
        bus.cmd_valid = 1'b1;
        watch = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort:ready", 32'(bus.cmd_ready), 32'd1);
        check("abort:done", 32'(bus.done), 32'd0);
        check("abort:wrt_enable", 32'(rf_wrt_enable), 32'd0);
        check("abort:result", 32'(bus.result), 32'd0);
        exp_z = 1'b0;
        exp_c = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        watch = 1'b0;
        check("abort:no_write_or_done", 32'(wr_seen), 32'd0);
        check("abort:ready_after", 32'(bus.cmd_ready), 32'd1);
        check_flags("abort");

        run_cmd("mov_r11", OP_MOV, 4'd11, 4'd10, 4'd0, 8'h00);
        run_cmd("nop_tail", OP_NOP, 4'd0, 4'd0, 4'd0, 8'h00);
        check("end:sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/rf_op_sequencer.md
# rf_op_sequencer

Command sequencer that drives the 16-entry register file: accepts one register-to-register operation per handshake, reads both sources, computes the result in a small ALU, and writes it back through the file's single write port. It sits between the instruction source (bench or fetch logic) and the register file, and it is the only master of the file's select, write-enable and write-data inputs.

## Interface
- W, 8, datapath width; matches register file width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode
- cmd_dst  in  4  destination register index
- cmd_src1  in  4  first source index
- cmd_src2  in  4  second source index
- cmd_imm  in  W  immediate operand, LDI only
- busy  out  1  command in flight
- done  out  1  one-cycle pulse at writeback
- result  out  W  value written, valid while done=1
- rf_src_sel1 / rf_src_sel2  out  4  to register file read selects
- rf_dest_sel  out  4  to register file destination select
- rf_wrt_enable  out  1  to register file write enable
- rf_wrt_data  out  W  to register file write data
- rf_read_data1 / rf_read_data2  in  W  from register file (combinational read)
- flag_zero / flag_carry  out  1  status flags (only with RF_SEQ_FLAGS_EN)

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (dst=src1), 110 LDI (dst=imm), 111 NOP.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid and cmd_ready are both high at a clock edge. On acceptance, op, dst, src1, src2 and imm are captured. The next state is READ, except LDI and NOP, which go directly to WB.
- READ: rf_src_sel1/2 = captured src1/src2. rf_read_data1/2 are sampled into operand registers at the end of the cycle. Next state: EXEC.
- EXEC: the ALU result is registered. Next state: WB.
- WB: rf_dest_sel = dst, rf_wrt_data = result, rf_wrt_enable = 1 (0 for NOP), done = 1. Next state: IDLE.
- Arithmetic is modulo 2^W.
  - ADD carry = carry out of bit W-1.
  - SUB = src1 - src2; carry = borrow (1 when src1 < src2, unsigned).
- Outside READ and WB, rf_src_sel*, rf_dest_sel and rf_wrt_data are 0, and rf_wrt_enable is 0.
- cmd_* inputs are ignored while busy.
- src equal to dst is legal: reads complete before the write.
- A command accepted the cycle after WB sees the value just written.

## Timing
- Reset (asynchronous, active-low): state=IDLE; cmd_ready=1; busy, done and all rf_* outputs are 0; result=0; flags=0. rf_wrt_enable drops immediately, without waiting for a clock edge.
- Reset mid-operation: the in-flight command is discarded, there is no write and no done pulse. The register file contents are untouched by the sequencer.
- Accept at edge 0:
  - ALU/MOV: READ in cycle 1, EXEC in cycle 2, WB in cycle 3 (write commits at edge 4). cmd_ready is high again in cycle 4.
  - LDI/NOP: WB in cycle 1, cmd_ready high in cycle 2.
- Throughput: one ALU command per 4 cycles; one LDI/NOP per 2 cycles.
- busy = !cmd_ready.

## Configuration
- RF_SEQ_FLAGS_EN defined: flag_zero and flag_carry ports exist and are registered at the WB edge.
  - ALU ops update both flags.
  - MOV and LDI update zero and clear carry.
  - NOP leaves both flags unchanged.
- RF_SEQ_FLAGS_EN undefined: the ports and flag logic are absent; all other behaviour is identical.

## Structure
- Shared package rf_seq_pkg holds:
  - opcode localparams (OP_ADD…OP_NOP);
  - FSM state encoding (ST_IDLE, ST_READ, ST_EXEC, ST_WB).
- One combinational sub-module, rf_seq_alu, takes (op, a, b, imm) and produces (y, carry). The FSM, capture registers and flag registers stay in rf_op_sequencer.

## Test plan
- LDI r3,0x12 then LDI r4,0x34: each gives done in cycle 1 with rf_wrt_enable=1, rf_dest_sel=3/4 and rf_wrt_data=0x12/0x34.
- ADD r5=r3+r4: rf_src_sel1=3 and rf_src_sel2=4 in cycle 1; WB in cycle 3 with rf_dest_sel=5, rf_wrt_data=0x46, carry=0, zero=0.
- SUB r6=r3-r4 gives result 0xDE, carry=1. ADD of 0xFF+0x01 gives 0x00, zero=1, carry=1.
- cmd_valid held high for ADD r3=r3+r3 followed by NOP:
  - ADD writes 0x24;
  - cmd_ready is low in cycles 1–3;
  - NOP is accepted at edge 4, pulses done at cycle 5 with rf_wrt_enable=0, and the flags are unchanged.
- Reset asserted in EXEC of an ADD: rf_wrt_enable is never 1 and no done pulse occurs. After release, cmd_ready=1, and a later MOV reads the old destination value.
